// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 key decoder.
// Optional feature macro: PS2_TIMEOUT_EN (partial-frame timeout).
package ps2_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] SC_E0        = 8'hE0;
    localparam logic [7:0] SC_F0        = 8'hF0;
    localparam logic [7:0] SC_JUMP_DEF  = 8'h24;
    localparam logic [7:0] SC_LEFT_DEF  = 8'h6B;
    localparam logic [7:0] SC_RIGHT_DEF = 8'h74;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;
`endif

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM,
// odd-parity/stop check. Emits a one-cycle byte_valid or err pulse per frame.
// Optional feature macro: PS2_TIMEOUT_EN drops a stalled partial frame.
module ps2_rx_frame
    import ps2_key_pkg::*;
`ifdef PS2_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);

    logic         clk_s1, clk_s2, clk_prev;
    logic         dat_s1, dat_s2;
    logic         fall;
    logic         timeout;
    frame_state_t state, next_state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;
    logic         par_bit;
    logic         shift_en, par_en, cnt_clr, frame_ok, frame_bad;

    // Two-stage synchronisers plus a delayed ps2_clk copy for edge detection; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

`ifdef PS2_TIMEOUT_EN
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);
    logic [16:0] to_cnt;

    // Idle-gap counter: runs only mid-frame, restarts on every PS/2 clock edge.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE || fall) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 17'd1;
        end
    end

    assign timeout = (state != ST_IDLE) && (to_cnt == TO_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one step per synced falling edge; timeout forces IDLE.
    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = ST_IDLE;
        end else if (fall) begin
            unique case (state)
                ST_IDLE:   if (!dat_s2) next_state = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) next_state = ST_PARITY;
                ST_PARITY: next_state = ST_STOP;
                ST_STOP:   next_state = ST_IDLE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Per-state control strobes and frame verdict.
    always_comb begin
        shift_en  = 1'b0;
        par_en    = 1'b0;
        cnt_clr   = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = timeout;
        if (fall && !timeout) begin
            unique case (state)
                ST_IDLE:   cnt_clr  = 1'b1;
                ST_DATA:   shift_en = 1'b1;
                ST_PARITY: par_en   = 1'b1;
                ST_STOP: begin
                    frame_ok  = dat_s2 && odd_parity_ok(shreg, par_bit);
                    frame_bad = ~frame_ok;
                end
                default: ;
            endcase
        end
    end

    // Datapath: LSB-first shift, parity capture, registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
            rx_byte    <= '0;
        end else begin
            if (cnt_clr) bit_cnt <= '0;
            if (shift_en) begin
                shreg   <= {dat_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_en) par_bit <= dat_s2;
            byte_valid <= frame_ok;
            err        <= frame_bad;
            if (frame_ok) rx_byte <= shreg;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: decodes Set-2 make/break (with E0 prefix) into
// held-key levels for jump/left/right and a one-cycle jump-press pulse.
// Optional feature macro: PS2_TIMEOUT_EN (partial-frame timeout in receiver).
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter logic [7:0] SC_JUMP  = SC_JUMP_DEF,
    parameter logic [7:0] SC_LEFT  = SC_LEFT_DEF,
    parameter logic [7:0] SC_RIGHT = SC_RIGHT_DEF
`ifdef PS2_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       e_key,
    output logic       e_press,
    output logic       left_key,
    output logic       right_key,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       err;
    logic       brk, ext;
    logic       e_key_d;
    logic       is_key_code;

`ifdef PS2_TIMEOUT_EN
    ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
`else
    ps2_rx_frame u_rx (
`endif
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .err        (err)
    );

    assign scan_valid  = byte_valid;
    assign scan_code   = rx_byte;
    assign frame_err   = err;
    assign is_key_code = byte_valid && (rx_byte != SC_E0) && (rx_byte != SC_F0);

    // Prefix flags: E0/F0 set them, any key code or a bad frame clears both.
    always_ff @(posedge clk) begin
        if (rst || err) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_E0) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_F0) begin
                brk <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    // Key levels: make sets, break clears; arrows only count when extended.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_key     <= 1'b0;
            left_key  <= 1'b0;
            right_key <= 1'b0;
        end else if (is_key_code) begin
            if (!ext && rx_byte == SC_JUMP)  e_key     <= ~brk;
            if (ext && rx_byte == SC_LEFT)   left_key  <= ~brk;
            if (ext && rx_byte == SC_RIGHT)  right_key <= ~brk;
        end
    end

    // Jump-press pulse from the e_key rising transition only.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_key_d <= 1'b0;
            e_press <= 1'b0;
        end else begin
            e_key_d <= e_key;
            e_press <= e_key & ~e_key_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder with a key-state reference model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int unsigned H = 8;   // PS/2 half bit period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       e_key, e_press, left_key, right_key, scan_valid, frame_err;
    logic [7:0] scan_code;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 500;
    ps2_key_decoder #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
`else
    ps2_key_decoder dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .e_key      (e_key),
        .e_press    (e_press),
        .left_key   (left_key),
        .right_key  (right_key),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .frame_err  (frame_err)
    );

    // Monitor: event counters and cycle stamps sampled on the falling clk edge.
    int cyc = 0;
    int n_sv = 0, n_err = 0, n_press = 0, press_long = 0;
    int sv_cyc = 0, ekey_cyc = 0, press_cyc = 0;
    logic prev_press = 1'b0, prev_ekey = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (scan_valid) begin n_sv++; sv_cyc = cyc; end
        if (frame_err) n_err++;
        if (e_press) begin
            if (!prev_press) begin n_press++; press_cyc = cyc; end
            else press_long++;
        end
        if (e_key && !prev_ekey) ekey_cyc = cyc;
        prev_press = e_press;
        prev_ekey  = e_key;
    end

    // Reference model: key levels and expected event counts.
    logic       m_e = 0, m_l = 0, m_r = 0, m_brk = 0, m_ext = 0;
    logic [7:0] m_code = '0;
    int         m_sv = 0, m_err = 0, m_press = 0;

    task automatic model_good(input logic [7:0] b);
        m_sv++;
        m_code = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext && b == 8'h24) begin
                if (!m_brk && !m_e) m_press++;
                m_e = !m_brk;
            end
            if (m_ext && b == 8'h6B) m_l = !m_brk;
            if (m_ext && b == 8'h74) m_r = !m_brk;
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic model_bad();
        m_err++;
        m_brk = 0;
        m_ext = 0;
    endtask

    task automatic model_reset();
        m_e = 0; m_l = 0; m_r = 0; m_brk = 0; m_ext = 0; m_code = '0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; a complete frame also waits for the result.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int unsigned nbits);
        logic [10:0] f;
        f = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) ps2_bit(f[i]);
        if (nbits == 11) repeat (H + 6) @(posedge clk);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1, 11);
        model_good(d);
    endtask

    task automatic send_bad(input logic [7:0] d, input logic bad_par, input logic stop);
        send_frame(d, bad_par, stop, 11);
        model_bad();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        model_reset();
        checks++;
        if ({e_key, e_press, left_key, right_key, scan_valid, scan_code, frame_err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {e_key, e_press, left_key, right_key, scan_valid, scan_code, frame_err});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        do_reset();
    endtask

    task automatic test_jump_press();
        send_good(8'h24);
        @(negedge clk);
        checks++;
        if (n_sv !== m_sv || scan_code !== 8'h24) begin
            failures++; $display("FAIL jump_scan got n=%0d code=%h exp n=%0d code=24", n_sv, scan_code, m_sv);
        end
        checks++;
        if (e_key !== 1'b1) begin failures++; $display("FAIL jump_level got=%b exp=1", e_key); end
        checks++;
        if (ekey_cyc !== sv_cyc + 1) begin
            failures++; $display("FAIL jump_key_latency got=%0d exp=%0d", ekey_cyc - sv_cyc, 1);
        end
        checks++;
        if (press_cyc !== ekey_cyc + 1 || n_press !== 1 || press_long !== 0) begin
            failures++;
            $display("FAIL jump_press got lat=%0d n=%0d long=%0d exp lat=1 n=1 long=0",
                     press_cyc - ekey_cyc, n_press, press_long);
        end
    endtask

    task automatic test_typematic();
        send_good(8'h24);
        send_good(8'h24);
        checks++;
        if (e_key !== 1'b1 || n_press !== m_press) begin
            failures++; $display("FAIL typematic_hold got key=%b n=%0d exp key=1 n=%0d", e_key, n_press, m_press);
        end
        send_good(8'hF0);
        send_good(8'h24);
        checks++;
        if (e_key !== 1'b0 || n_press !== 1 || press_long !== 0) begin
            failures++; $display("FAIL typematic_break got key=%b n=%0d exp key=0 n=1", e_key, n_press);
        end
    endtask

    task automatic test_arrows();
        send_good(8'hE0); send_good(8'h6B);
        checks++;
        if ({left_key, right_key} !== 2'b10) begin
            failures++; $display("FAIL left_make got=%b exp=10", {left_key, right_key});
        end
        send_good(8'hE0); send_good(8'h74);
        checks++;
        if ({left_key, right_key} !== 2'b11) begin
            failures++; $display("FAIL both_held got=%b exp=11", {left_key, right_key});
        end
        send_good(8'hE0); send_good(8'hF0); send_good(8'h6B);
        checks++;
        if ({left_key, right_key} !== 2'b01) begin
            failures++; $display("FAIL left_break got=%b exp=01", {left_key, right_key});
        end
        send_good(8'h6B);
        checks++;
        if ({left_key, right_key} !== 2'b01) begin
            failures++; $display("FAIL keypad_6b got=%b exp=01", {left_key, right_key});
        end
        send_good(8'hF0); send_good(8'h74);
        checks++;
        if ({left_key, right_key} !== 2'b01) begin
            failures++; $display("FAIL keypad_brk74 got=%b exp=01", {left_key, right_key});
        end
        send_good(8'hE0); send_good(8'hF0); send_good(8'h74);
        checks++;
        if ({left_key, right_key} !== 2'b00) begin
            failures++; $display("FAIL right_break got=%b exp=00", {left_key, right_key});
        end
    endtask

    task automatic test_errors();
        send_bad(8'h1C, 1'b1, 1'b1);
        checks++;
        if (n_err !== m_err || n_sv !== m_sv || scan_code !== m_code) begin
            failures++;
            $display("FAIL bad_parity got err=%0d sv=%0d code=%h exp err=%0d sv=%0d code=%h",
                     n_err, n_sv, scan_code, m_err, m_sv, m_code);
        end
        checks++;
        if ({e_key, left_key, right_key} !== {m_e, m_l, m_r}) begin
            failures++; $display("FAIL bad_parity_keys got=%b exp=%b", {e_key, left_key, right_key}, {m_e, m_l, m_r});
        end
        send_bad(8'hF0, 1'b0, 1'b0);
        send_good(8'h24);
        checks++;
        if (n_err !== m_err || e_key !== 1'b1 || n_press !== m_press) begin
            failures++;
            $display("FAIL bad_stop_then_make got err=%0d key=%b n=%0d exp err=%0d key=1 n=%0d",
                     n_err, e_key, n_press, m_err, m_press);
        end
    endtask

    task automatic test_timeout();
        send_frame(8'h24, 1'b0, 1'b1, 5);
`ifdef PS2_TIMEOUT_EN
        repeat (TB_TIMEOUT + 50) @(posedge clk);
        model_bad();
        checks++;
        if (n_err !== m_err) begin failures++; $display("FAIL timeout_err got=%0d exp=%0d", n_err, m_err); end
`else
        repeat (2000) @(posedge clk);
        checks++;
        if (n_err !== m_err) begin failures++; $display("FAIL no_timeout got=%0d exp=%0d", n_err, m_err); end
        do_reset();
`endif
        send_good(8'hF0); send_good(8'h24); send_good(8'h24);
        checks++;
        if (n_sv !== m_sv || scan_code !== 8'h24 || e_key !== 1'b1 || n_press !== m_press) begin
            failures++;
            $display("FAIL after_partial got sv=%0d code=%h key=%b n=%0d exp sv=%0d code=24 key=1 n=%0d",
                     n_sv, scan_code, e_key, n_press, m_sv, m_press);
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h6B, 1'b0, 1'b1, 5);
        do_reset();
        send_good(8'h24);
        checks++;
        if (e_key !== 1'b1 || n_press !== m_press || scan_code !== 8'h24) begin
            failures++;
            $display("FAIL post_reset_make got key=%b n=%0d code=%h exp key=1 n=%0d code=24",
                     e_key, n_press, scan_code, m_press);
        end
    endtask

    task automatic test_random();
        logic [7:0] pick [6];
        logic [7:0] b;
        int unsigned kind;
        pick = '{8'h24, 8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C};
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            b = 8'($urandom);
            if (kind <= 5) send_good(pick[kind]);
            else if (kind == 6) send_good(b);
            else if (kind == 7) send_bad(b, 1'b1, 1'b1);
            else if (kind == 8) send_bad(b, 1'b0, 1'b0);
            else send_good(8'hE0);
            checks++;
            if ({e_key, left_key, right_key} !== {m_e, m_l, m_r} || n_sv !== m_sv || n_err !== m_err
                || n_press !== m_press || scan_code !== m_code) begin
                failures++;
                $display("FAIL random_%0d got keys=%b sv=%0d err=%0d press=%0d code=%h exp keys=%b sv=%0d err=%0d press=%0d code=%h",
                         n, {e_key, left_key, right_key}, n_sv, n_err, n_press, scan_code,
                         {m_e, m_l, m_r}, m_sv, m_err, m_press, m_code);
            end
        end
        checks++;
        if (press_long !== 0) begin failures++; $display("FAIL press_width got=%0d exp=0", press_long); end
    endtask

    initial begin
        test_reset();
        test_jump_press();
        test_typematic();
        test_arrows();
        test_errors();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
